// File: rtl/dual_bit_serializer.sv
// Parallel-to-serial stimulus stage for two-input bit-serial FSMs: shifts word_x/word_y
// out MSB-first on x/y and collects the FSM's z response into resp.
module dual_bit_serializer #(
   parameter int WIDTH = 16,
   parameter int Z_LAT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] word_x,
   input  logic [WIDTH-1:0] word_y,
   input  logic             z_in,
   output logic             x,
   output logic             y,
   output logic             bit_valid,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] resp,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_sx;
   logic [WIDTH-1:0] r_sy;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_inc;
   logic             w_last;
   logic             w_load;
   logic             r_bv_d;
   logic             w_cap_en;

   // Load handshake: a word pair transfers at a rising edge where load_valid and
   // load_ready are both high; load_ready is high only in IDLE, so offers made while
   // busy are dropped, never queued.
   assign w_load    = (r_state == S_IDLE) && load_valid;
   assign w_cnt_inc = r_cnt + CW'(1);
   assign w_last    = (w_cnt_inc == CW'(WIDTH));
   assign w_cap_en  = (Z_LAT == 1) ? r_bv_d : bit_valid;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (load_valid) w_next = S_SHIFT;
         S_SHIFT: if (w_last) w_next = (Z_LAT == 1) ? S_DRAIN : S_DONE;
         S_DRAIN: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they are flops, not gates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         load_ready <= 1'b1;
         bit_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         r_state    <= w_next;
         load_ready <= (w_next == S_IDLE);
         bit_valid  <= (w_next == S_SHIFT);
         busy       <= (w_next == S_SHIFT) || (w_next == S_DRAIN);
         done       <= (w_next == S_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sx   <= '0;
         r_sy   <= '0;
         r_cnt  <= '0;
         resp   <= '0;
         r_bv_d <= 1'b0;
      end else begin
         r_bv_d <= bit_valid;
         if (w_load) begin
            r_sx  <= word_x;
            r_sy  <= word_y;
            r_cnt <= '0;
            resp  <= '0;
         end else begin
            if (r_state == S_SHIFT) begin
               r_sx  <= {r_sx[WIDTH-2:0], 1'b0};
               r_sy  <= {r_sy[WIDTH-2:0], 1'b0};
               r_cnt <= w_cnt_inc;
            end
            if (w_cap_en) resp <= {resp[WIDTH-2:0], z_in};
         end
      end
   end

   // After WIDTH shifts the registers hold only zeros, so x/y idle low outside SHIFT.
   assign x         = r_sx[WIDTH-1];
   assign y         = r_sy[WIDTH-1];
   assign state_dbg = r_state;

endmodule

// File: tb/tb_dual_bit_serializer.sv
// Directed bench for dual_bit_serializer: Mealy and registered-z runs, busy-load
// rejection, mid-run reset and a narrow back-to-back configuration.
`timescale 1ns/1ps
module tb_dual_bit_serializer;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // DUT a: WIDTH=16, Mealy z
   logic        a_lv = 1'b0, a_lr, a_x, a_y, a_bv, a_busy, a_done, a_z;
   logic [15:0] a_wx = '0, a_wy = '0, a_resp;
   logic [1:0]  a_st;
   int          a_mode = 0;
   always_comb a_z = (a_mode == 0) ? (a_x ^ a_y) : (a_x | a_y);

   dual_bit_serializer #(.WIDTH(16), .Z_LAT(0)) u_a (
      .clk(clk), .rst(rst), .load_valid(a_lv), .load_ready(a_lr),
      .word_x(a_wx), .word_y(a_wy), .z_in(a_z), .x(a_x), .y(a_y),
      .bit_valid(a_bv), .busy(a_busy), .done(a_done), .resp(a_resp), .state_dbg(a_st)
   );

   // DUT b: WIDTH=16, registered z
   logic        b_lv = 1'b0, b_lr, b_x, b_y, b_bv, b_busy, b_done;
   logic        b_z = 1'b0;
   logic [15:0] b_wx = '0, b_wy = '0, b_resp;
   logic [1:0]  b_st;
   always @(posedge clk) b_z <= b_x & b_y;

   dual_bit_serializer #(.WIDTH(16), .Z_LAT(1)) u_b (
      .clk(clk), .rst(rst), .load_valid(b_lv), .load_ready(b_lr),
      .word_x(b_wx), .word_y(b_wy), .z_in(b_z), .x(b_x), .y(b_y),
      .bit_valid(b_bv), .busy(b_busy), .done(b_done), .resp(b_resp), .state_dbg(b_st)
   );

   // DUT c: WIDTH=4, Mealy z = x
   logic       c_lv = 1'b0, c_lr, c_x, c_y, c_bv, c_busy, c_done, c_z;
   logic [3:0] c_wx = '0, c_wy = '0, c_resp;
   logic [1:0] c_st;
   assign c_z = c_x;

   dual_bit_serializer #(.WIDTH(4), .Z_LAT(0)) u_c (
      .clk(clk), .rst(rst), .load_valid(c_lv), .load_ready(c_lr),
      .word_x(c_wx), .word_y(c_wy), .z_in(c_z), .x(c_x), .y(c_y),
      .bit_valid(c_bv), .busy(c_busy), .done(c_done), .resp(c_resp), .state_dbg(c_st)
   );

   // scoreboard of expected {x,y} pairs for the run in flight
   logic [1:0] exp_q[$];

   task automatic push_bits(input logic [15:0] wx, input logic [15:0] wy);
      exp_q.delete();
      for (int i = 15; i >= 0; i--) exp_q.push_back({wx[i], wy[i]});
   endtask

   // driver: one WIDTH=16 Mealy run on DUT a, entered at a negedge while idle
   task automatic a_run(input logic [15:0] wx, input logic [15:0] wy,
                        input logic [15:0] exp_resp, input bit busy_pulse);
      int cyc;
      int nbits;
      logic [1:0] e;
      push_bits(wx, wy);
      check_eq("a_ready_before_load", a_lr, 1);
      a_wx = wx; a_wy = wy; a_lv = 1'b1;
      @(negedge clk);
      a_lv = 1'b0; a_wx = 16'hFFFF; a_wy = 16'h0000;
      cyc = 1; nbits = 0;
      while (a_done !== 1'b1 && cyc < 40) begin
         if (a_bv === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
            check_eq("a_xy_bit", {a_x, a_y}, e);
            nbits++;
         end
         if (busy_pulse && cyc == 6) begin
            check_eq("a_ready_while_busy", a_lr, 0);
            a_lv = 1'b1; a_wx = 16'hFFFF; a_wy = 16'hFFFF;
         end
         if (busy_pulse && cyc == 7) a_lv = 1'b0;
         @(negedge clk);
         cyc++;
      end
      check_eq("a_done_latency", cyc, 17);
      check_eq("a_bit_count", nbits, 16);
      check_eq("a_resp", a_resp, exp_resp);
      check_eq("a_xy_low_in_done", {a_x, a_y, a_bv, a_busy}, 0);
      @(negedge clk);
      check_eq("a_done_one_cycle", a_done, 0);
      check_eq("a_ready_after_done", a_lr, 1);
      check_eq("a_resp_held", a_resp, exp_resp);
   endtask

   task automatic b_run(input logic [15:0] wx, input logic [15:0] wy, input logic [15:0] exp_resp);
      int cyc;
      int drain_cycles;
      logic [1:0] e;
      push_bits(wx, wy);
      b_wx = wx; b_wy = wy; b_lv = 1'b1;
      @(negedge clk);
      b_lv = 1'b0;
      cyc = 1; drain_cycles = 0;
      while (b_done !== 1'b1 && cyc < 40) begin
         if (b_bv === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
            check_eq("b_xy_bit", {b_x, b_y}, e);
         end
         if (b_busy === 1'b1 && b_bv === 1'b0) begin
            drain_cycles++;
            check_eq("b_drain_state", b_st, 2);
            check_eq("b_drain_cycle", cyc, 17);
            check_eq("b_xy_low_in_drain", {b_x, b_y}, 0);
         end
         @(negedge clk);
         cyc++;
      end
      check_eq("b_done_latency", cyc, 18);
      check_eq("b_drain_count", drain_cycles, 1);
      check_eq("b_bits_consumed", exp_q.size(), 0);
      check_eq("b_resp", b_resp, exp_resp);
      @(negedge clk);
      check_eq("b_idle_after_done", {b_lr, b_done, b_busy}, 3'b100);
   endtask

   task automatic a_mid_reset();
      int cyc;
      int done_seen;
      a_mode = 1;
      a_wx = 16'h3BC7; a_wy = 16'h3BF8; a_lv = 1'b1;
      @(negedge clk);
      a_lv = 1'b0;
      for (cyc = 1; cyc < 9; cyc++) @(negedge clk);
      check_eq("a_pre_reset_bv", a_bv, 1);
      check_eq("a_pre_reset_resp", a_resp, 16'h003B);
      rst = 1'b0;
      a_lv = 1'b1;
      #1;
      check_eq("a_reset_outs", {a_lr, a_x, a_y, a_bv, a_busy, a_done}, 6'b100000);
      check_eq("a_reset_resp", a_resp, 0);
      check_eq("a_reset_state", a_st, 0);
      @(negedge clk);
      check_eq("a_reset_hold", {a_lr, a_busy, a_done}, 3'b100);
      rst = 1'b1;
      a_lv = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (a_done === 1'b1) done_seen++;
      end
      check_eq("a_no_done_after_reset", done_seen, 0);
   endtask

   task automatic c_run();
      logic [3:0] resp_exp_q[$];
      int         cyc_exp_q[$];
      int         cyc_exp;
      logic [3:0] r_exp;
      resp_exp_q = '{4'h9, 4'h5};
      cyc_exp_q  = '{5, 11};
      c_wx = 4'h9; c_wy = 4'h6; c_lv = 1'b1;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin c_wx = 4'h5; c_wy = 4'h3; end
         if (cyc == 6) check_eq("c_idle_gap", {c_lr, c_busy, c_st}, 4'b1000);
         if (c_done === 1'b1) begin
            cyc_exp = (cyc_exp_q.size() > 0) ? cyc_exp_q.pop_front() : -1;
            r_exp   = (resp_exp_q.size() > 0) ? resp_exp_q.pop_front() : 4'hx;
            check_eq("c_done_cycle", cyc, cyc_exp);
            check_eq("c_resp", c_resp, r_exp);
            if (cyc == 11) c_lv = 1'b0;
         end
      end
      check_eq("c_loads_completed", resp_exp_q.size(), 0);
      check_eq("c_final_idle", {c_lr, c_busy, c_done}, 3'b100);
   endtask

   initial begin
      // reset with load_valid offered on every DUT
      a_lv = 1'b1; a_wx = 16'h1234; a_wy = 16'h5678;
      b_lv = 1'b1; c_lv = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_a_outs", {a_lr, a_x, a_y, a_bv, a_busy, a_done}, 6'b100000);
      check_eq("rst_a_resp", a_resp, 0);
      check_eq("rst_b_outs", {b_lr, b_x, b_y, b_bv, b_busy, b_done}, 6'b100000);
      check_eq("rst_c_outs", {c_lr, c_bv, c_busy, c_done, c_resp}, 8'b10000000);
      rst = 1'b1;
      a_lv = 1'b0; b_lv = 1'b0; c_lv = 1'b0;
      @(negedge clk);
      check_eq("rst_no_load", {a_lr, a_busy, a_st}, 4'b1000);

      a_mode = 0;
      a_run(16'h3BC7, 16'h3BF8, 16'h003F, 1'b0);
      b_run(16'h3BC7, 16'h3BF8, 16'h3BC0);
      a_run(16'h3BC7, 16'h3BF8, 16'h003F, 1'b1);
      a_mid_reset();
      a_run(16'hAAAA, 16'h5555, 16'hFFFF, 1'b0);
      c_run();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dual_bit_serializer.md
# dual_bit_serializer

Upstream stimulus stage for the two-input bit-serial sequence FSMs (x, y in; z out). It accepts a pair of parallel words through a valid/ready load handshake and shifts them out MSB-first as synchronized x/y bit streams, one bit per clock. It captures the FSM's z response into a parallel word and signals completion with a one-cycle pulse. This lets the FSM run from a parallel host or from a self-checking wrapper without per-bit stimulus.

## Interface
- WIDTH, 16: bits per word; legal range 2..64.
- Z_LAT, 0: cycles from a presented x/y bit to its z; 0 = Mealy (z valid in the same cycle), 1 = registered/Moore z.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserts immediately when low; released synchronously to clk by the system).
- load_valid  input  1  host offers word_x/word_y.
- load_ready  output  1  block can accept a load (high only in IDLE).
- word_x  input  WIDTH  word serialized onto x.
- word_y  input  WIDTH  word serialized onto y.
- z_in  input  1  response bit from the downstream FSM.
- x  output  1  serial bit to FSM x input, registered.
- y  output  1  serial bit to FSM y input, registered.
- bit_valid  output  1  x/y carry a payload bit this cycle.
- busy  output  1  high in SHIFT and DRAIN.
- done  output  1  one-cycle completion pulse.
- resp  output  WIDTH  captured z bits; first-captured bit in resp[WIDTH-1].

## Operation
- States: IDLE, SHIFT, DRAIN, DONE. DRAIN exists only when Z_LAT=1.
- IDLE
  - load_ready=1, x=y=0, bit_valid=0.
  - When load_valid is high at a rising edge, latch word_x/word_y into shift registers, clear resp and the bit counter, and go to SHIFT.
- SHIFT
  - Each cycle, x/y present the current MSB and bit_valid=1.
  - At each edge, shift both registers left and increment the counter.
  - After WIDTH bits are presented, go to DRAIN if Z_LAT=1, otherwise go to DONE.
- DRAIN (Z_LAT=1 only)
  - x=y=0, bit_valid=0.
  - Lasts one cycle and captures the last z bit.
- DONE
  - done=1 for one cycle; resp is stable and final.
  - Next state is IDLE.
- z capture
  - Enable = bit_valid delayed by Z_LAT cycles.
  - On each enabled edge: resp <= {resp[WIDTH-2:0], z_in}.
  - Exactly WIDTH captures per load.
- resp holds its value through DONE and IDLE until the next accepted load clears it.
- The bit counter is ceil(log2(WIDTH+1)) bits wide and compared to WIDTH. No wrap-around is permitted.

## Timing
- Reset values:
  - State IDLE; load_ready=1.
  - x=0, y=0, bit_valid=0, busy=0, done=0.
  - resp=0, shift registers=0, counter=0.
- Load accepted at edge E0. Bit i (MSB=i0) is presented in cycle E0+1+i, for i=0..WIDTH-1.
- done is high in the cycle after edge E0+WIDTH+Z_LAT. Total latency from load to done is WIDTH+1+Z_LAT cycles.
- The earliest next load is at the edge ending the DONE cycle plus one; IDLE occupies at least one cycle.
- load_valid while load_ready=0 is ignored; there is no queuing and no change to the words in flight.
- word_x/word_y are sampled only at the accepting edge; later changes have no effect.
- rst low mid-operation: immediate return to IDLE with all reset values. resp is lost and done is not asserted.
- load_valid high during the reset cycle is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: drive rst=0 with load_valid=1 -> load_ready=1, x=y=bit_valid=busy=done=0, resp=0; no load is accepted.
- Mealy run (Z_LAT=0, WIDTH=16): load word_x=0x3BC7, word_y=0x3BF8; bench drives z_in=x^y combinationally.
  - x sequence is 0,0,1,1,1,0,1,1,1,1,0,0,0,1,1,1.
  - done arrives 17 cycles after the load edge.
  - resp=0x003F.
- Registered run (Z_LAT=1): same words; bench drives z_in = (x&y) registered.
  - DRAIN is observed for one cycle.
  - done arrives 18 cycles after the load edge.
  - resp=0x3BC0.
- Busy load: pulse load_valid with 0xFFFF/0xFFFF at bit 5 of a 0x3BC7/0x3BF8 run -> remaining x/y bits are unchanged and resp matches the first run.
- Mid-run reset: assert rst at bit 8 -> all outputs take reset values within the same cycle and done never pulses. A following load of 0xAAAA/0x5555 with z_in=x|y gives resp=0xFFFF.
- WIDTH=4: load 0x9/0x6 with z_in=x -> done after 5 cycles and resp=0x9. Two back-to-back loads are separated by one IDLE cycle.
